// File: rtl/systolic_operand_feeder.sv
// Operand feeder for a row of MAC PEs: buffers A/B/C vector beats in a FIFO and
// drives them out as a diagonal wavefront, lane i delayed by i cycles.
module systolic_operand_feeder #(
    parameter int REG_WIDTH  = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           cfg_len,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*REG_WIDTH-1:0] in_a,
    input  logic [LANES*REG_WIDTH-1:0] in_b,
    input  logic [LANES*REG_WIDTH-1:0] in_c,
    output logic [LANES*REG_WIDTH-1:0] out_a_n_1,
    output logic [LANES*REG_WIDTH-1:0] out_b_n_1,
    output logic [LANES*REG_WIDTH-1:0] out_c_n_1,
    output logic [LANES-1:0]           out_valid
);
    localparam int DW    = LANES * REG_WIDTH;
    localparam int LW    = 3 * REG_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  beats_left_q, beats_left_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              done_q, done_d;

    logic [3*DW-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              push, pop, fifo_empty, fifo_full;
    logic [3*DW-1:0]   rd_data;

    logic [LANES-1:0][LW-1:0] stage_in;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == OCC_W'(FIFO_DEPTH));
    assign push       = in_valid && !fifo_full;
    assign rd_data    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the occupancy counter alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_c, in_b, in_a};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beats_left_q <= '0;
            drain_cnt_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            drain_cnt_q  <= drain_cnt_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        drain_cnt_d  = drain_cnt_q;
        done_d       = 1'b0;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        state_d      = S_STREAM;
                        beats_left_d = cfg_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (!fifo_empty && beats_left_q != '0) begin
                    pop          = 1'b1;
                    beats_left_d = beats_left_q - LEN_W'(1);
                    if (beats_left_q == LEN_W'(1)) begin
                        if (LANES == 1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = CNT_W'(LANES - 1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q <= CNT_W'(1)) begin
                    state_d     = S_IDLE;
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = done_q;
        in_ready = !fifo_full;
    end

    // Bubbles enter as all-zero words so idle lanes drive zeros downstream.
    always_comb begin
        stage_in = '0;
        if (pop) begin
            for (int i = 0; i < LANES; i++) begin
                stage_in[i] = {1'b1,
                               rd_data[2*DW + i*REG_WIDTH +: REG_WIDTH],
                               rd_data[DW   + i*REG_WIDTH +: REG_WIDTH],
                               rd_data[       i*REG_WIDTH +: REG_WIDTH]};
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LW-1:0] sr_q [g+1];
        logic [LW-1:0] sr_d [g+1];

        always_comb begin
            sr_d[0] = stage_in[g];
            for (int k = 1; k <= g; k++) begin
                sr_d[k] = sr_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= g; k++) begin
                    sr_q[k] <= '0;
                end
            end else begin
                sr_q <= sr_d;
            end
        end

        assign out_a_n_1[g*REG_WIDTH +: REG_WIDTH] = sr_q[g][REG_WIDTH-1:0];
        assign out_b_n_1[g*REG_WIDTH +: REG_WIDTH] = sr_q[g][2*REG_WIDTH-1:REG_WIDTH];
        assign out_c_n_1[g*REG_WIDTH +: REG_WIDTH] = sr_q[g][3*REG_WIDTH-1:2*REG_WIDTH];
        assign out_valid[g]                        = sr_q[g][LW-1];
    end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed self-checking bench for systolic_operand_feeder (LANES=4, FIFO_DEPTH=8).
// Expected wavefronts are hand-tabulated beat ids per lane (lane 0 in the low byte).
module tb_systolic_operand_feeder;
    localparam int RW    = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int LEN_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [LEN_W-1:0]      cfg_len;
    logic                  busy, done;
    logic                  in_valid, in_ready;
    logic [LANES*RW-1:0]   in_a, in_b, in_c;
    logic [LANES*RW-1:0]   out_a_n_1, out_b_n_1, out_c_n_1;
    logic [LANES-1:0]      out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] t2 [1:6];
    logic [31:0] t3 [1:11];
    logic [31:0] t5 [1:6];
    logic [31:0] t7 [1:5];

    always #5 clk = ~clk;

    systolic_operand_feeder #(
        .REG_WIDTH (RW),
        .LANES     (LANES),
        .FIFO_DEPTH(DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .done     (done),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_c     (in_c),
        .out_a_n_1(out_a_n_1),
        .out_b_n_1(out_b_n_1),
        .out_c_n_1(out_c_n_1),
        .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane i word of beat id: 0x10*id + i, offset by base (A=0, B=0x1000, C=0x2000).
    function automatic logic [63:0] beat_vec(input logic [15:0] base, input int id);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            v[i*RW +: RW] = base + 16'(16 * id + i);
        end
        return v;
    endfunction

    task automatic check_ids(input string tag, input logic [31:0] ids);
        logic [3:0]  ev;
        logic [63:0] ea, eb, ec;
        int          id;
        ev = '0; ea = '0; eb = '0; ec = '0;
        for (int i = 0; i < LANES; i++) begin
            id = int'(ids[i*8 +: 8]);
            if (id != 0) begin
                ev[i]        = 1'b1;
                ea[i*RW +: RW] = 16'(16 * id + i);
                eb[i*RW +: RW] = 16'h1000 + 16'(16 * id + i);
                ec[i*RW +: RW] = 16'h2000 + 16'(16 * id + i);
            end
        end
        check({tag, ".valid"}, 64'(out_valid), 64'(ev));
        check({tag, ".a"}, out_a_n_1, ea);
        check({tag, ".b"}, out_b_n_1, eb);
        check({tag, ".c"}, out_c_n_1, ec);
    endtask

    task automatic drive_beat(input int id);
        in_valid = 1'b1;
        in_a     = beat_vec(16'h0000, id);
        in_b     = beat_vec(16'h1000, id);
        in_c     = beat_vec(16'h2000, id);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ids;
        t2 = '{32'h00000001, 32'h00000102, 32'h00010203,
               32'h01020300, 32'h02030000, 32'h03000000};
        t3 = '{32'h00000000, 32'h00000005, 32'h00000500, 32'h00050006,
               32'h05000600, 32'h00060007, 32'h06000700, 32'h00070008,
               32'h07000800, 32'h00080000, 32'h08000000};
        t5 = '{32'h00000000, 32'h00000003, 32'h00000304,
               32'h00030400, 32'h03040000, 32'h04000000};
        t7 = '{32'h00000007, 32'h00000708, 32'h00070800,
               32'h07080000, 32'h08000000};

        rst_n = 1'b1; start = 1'b0; cfg_len = '0;
        idle_in();

        // Asynchronous reset asserted between clock edges
        #3 rst_n = 1'b0;
        #1;
        check("rst.busy",     64'(busy),     64'd0);
        check("rst.done",     64'(done),     64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check_ids("rst", 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("idle.busy", 64'(busy), 64'd0);
        check_ids("idle", 32'h0);

        // Prefill three beats, then a len=3 tile
        for (int id = 1; id <= 3; id++) begin
            drive_beat(id);
            step();
            check($sformatf("pre%0d.in_ready", id), 64'(in_ready), 64'd1);
            check($sformatf("pre%0d.busy", id), 64'(busy), 64'd0);
        end
        idle_in();
        start = 1'b1; cfg_len = 8'd3;
        step();
        start = 1'b0;
        check("t2.start.busy", 64'(busy), 64'd1);
        check_ids("t2.k0", 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_ids($sformatf("t2.k%0d", k), t2[k]);
            check($sformatf("t2.k%0d.done", k), 64'(done), 64'(k == 6));
            check($sformatf("t2.k%0d.busy", k), 64'(busy), 64'(k < 6));
        end
        step();
        check("t2.after.done", 64'(done), 64'd0);

        // Starved stream: one beat every other cycle
        start = 1'b1; cfg_len = 8'd4;
        step();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k % 2 == 1 && k <= 7) drive_beat(5 + (k - 1) / 2);
            else idle_in();
            step();
            check_ids($sformatf("t3.k%0d", k), t3[k]);
            check($sformatf("t3.k%0d.done", k), 64'(done), 64'(k == 11));
            check($sformatf("t3.k%0d.busy", k), 64'(busy), 64'(k < 11));
        end

        // Back-pressure: fill the FIFO in IDLE, ninth beat must wait
        for (int id = 1; id <= 8; id++) begin
            drive_beat(id);
            step();
            check($sformatf("bp%0d.in_ready", id), 64'(in_ready), 64'(id < 8));
        end
        drive_beat(9);
        step();
        check("bp9.held.in_ready", 64'(in_ready), 64'd0);
        start = 1'b1; cfg_len = 8'd9;
        step();
        start = 1'b0;
        check("t4.start.busy",     64'(busy),     64'd1);
        check("t4.start.in_ready", 64'(in_ready), 64'd0);
        for (int k = 1; k <= 12; k++) begin
            if (k > 2) idle_in();
            step();
            ids = '0;
            for (int i = 0; i < LANES; i++) begin
                if (k - i >= 1 && k - i <= 9) ids[i*8 +: 8] = 8'(k - i);
            end
            check_ids($sformatf("t4.k%0d", k), ids);
            check($sformatf("t4.k%0d.done", k), 64'(done), 64'(k == 12));
            if (k == 1) check("t4.k1.in_ready", 64'(in_ready), 64'd1);
        end

        // Zero-length tile
        start = 1'b1; cfg_len = 8'd0;
        step();
        start = 1'b0;
        check("len0.done", 64'(done), 64'd1);
        check("len0.busy", 64'(busy), 64'd0);
        step();
        check("len0.next.done", 64'(done), 64'd0);
        check("len0.next.busy", 64'(busy), 64'd0);

        // start pulsed mid-STREAM with a different length must be ignored
        start = 1'b1; cfg_len = 8'd2;
        step();
        check("t5.start.busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin
                start = 1'b1; cfg_len = 8'd5;
                drive_beat(3);
            end else if (k == 2) begin
                start = 1'b0;
                drive_beat(4);
            end else begin
                idle_in();
            end
            step();
            check_ids($sformatf("t5.k%0d", k), t5[k]);
            check($sformatf("t5.k%0d.done", k), 64'(done), 64'(k == 6));
            check($sformatf("t5.k%0d.busy", k), 64'(busy), 64'(k < 6));
        end

        // Back-to-back start in the done cycle, then reset during DRAIN
        start = 1'b1; cfg_len = 8'd2;
        step();
        start = 1'b0;
        check("t6.b2b.busy", 64'(busy), 64'd1);
        check("t6.b2b.done", 64'(done), 64'd0);
        drive_beat(1); step();
        drive_beat(2); step();
        idle_in();     step();
        step();
        check_ids("t6.drain", 32'h00010200);
        check("t6.drain.busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst.busy",     64'(busy),     64'd0);
        check("t6.rst.done",     64'(done),     64'd0);
        check("t6.rst.in_ready", 64'(in_ready), 64'd1);
        check_ids("t6.rst", 32'h0);
        step();
        check("t6.rst.hold.done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();
        check("t6.post.done", 64'(done), 64'd0);
        check("t6.post.busy", 64'(busy), 64'd0);
        check_ids("t6.post", 32'h0);

        // Clean len=2 tile after the abort
        start = 1'b1; cfg_len = 8'd2;
        drive_beat(7);
        step();
        start = 1'b0;
        check("t7.start.busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) drive_beat(8);
            else idle_in();
            step();
            check_ids($sformatf("t7.k%0d", k), t7[k]);
            check($sformatf("t7.k%0d.done", k), 64'(done), 64'(k == 5));
            check($sformatf("t7.k%0d.busy", k), 64'(busy), 64'(k < 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_operand_feeder.md
# systolic_operand_feeder

Operand feeder for a row of integer MAC processing elements. It buffers vector beats of A, B and C operands arriving on a valid/ready stream, then drives the PE row's per-lane a_n_1/b_n_1/c_n_1 inputs as a diagonal wavefront, delaying lane i by i cycles. A start/len/done control interface frames each tile. It is the transmit end of the PE operand interface; the PEs have no back-pressure, so the feeder owns all pacing.

## Interface
- REG_WIDTH, 16, width of each operand word (matches PE REG_WIDTH)
- LANES, 4, number of PE lanes driven (≥1)
- FIFO_DEPTH, 8, beats buffered (power of 2, ≥2)
- LEN_W, 8, width of tile length field
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin tile; sampled only in IDLE
- cfg_len  in  LEN_W  beats in tile, sampled with start
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse at tile completion
- in_valid  in  1  input beat valid
- in_ready  out  1  FIFO not full
- in_a, in_b, in_c  in  LANES*REG_WIDTH each  beat operands; lane i = bits [i*REG_WIDTH +: REG_WIDTH]
- out_a_n_1, out_b_n_1, out_c_n_1  out  LANES*REG_WIDTH each  skewed operands to PE row
- out_valid  out  LANES  per-lane operand valid

## Operation
- FIFO: push on in_valid && in_ready, in any state (prefetch allowed in IDLE). in_ready = !full, registered occupancy; a push while full is not possible.
- States IDLE, STREAM, DRAIN.
- IDLE: start && cfg_len≠0 → load beats_left=cfg_len, go STREAM. start && cfg_len==0 → done pulses next cycle, stay IDLE. start in STREAM/DRAIN ignored.
- STREAM: each cycle FIFO non-empty → pop one beat into skew stage 0 with valid=1, beats_left−1; FIFO empty → bubble (data 0, valid 0), beats_left unchanged. Pop of last beat → DRAIN with drain_cnt=LANES−1; if LANES==1, go directly to IDLE with done.
- DRAIN: no pops; bubbles enter stage 0; drain_cnt decrements each cycle; on reaching 0 → IDLE, done.
- Skew: lane i output is stage-0 content delayed i further cycles (per-lane shift registers of depth i+1, shifting every cycle unconditionally). Valid bits travel with data; invalid lanes drive zeros.
- No arithmetic on data; words pass bit-exact. beats_left is LEN_W bits, never wraps (stops at 0).
- Reset (any time, incl. mid-tile): FIFO empty, skew registers cleared, state IDLE, tile aborted, no done.

## Timing
- Reset values: busy=0, done=0, out_valid=0, all out_* data=0, in_ready=1.
- Pop on edge E → lane 0 shows beat after E, lane i after E+i.
- Input-to-lane-0 latency through empty FIFO in STREAM: push at edge E, pop at E+1, lane 0 valid after E+1.
- done and busy=0 appear after edge E_last+LANES−1, same cycle lane LANES−1 shows the final beat.
- start accepted at edge S → busy=1 after S; first pop possible at S+1.
- Simultaneous push and pop: both occur, occupancy unchanged.
- Back-to-back tiles: start may be asserted in the cycle done is high (state is IDLE); accepted on that edge.

## Test plan
- Reset then idle: rst_n low mid-cycle → all outputs 0, in_ready=1, busy=0 immediately (async).
- LANES=4, prefill 3 beats (lane i value = 0x10*beat+i), start len=3 → lane 0 valid cycles 1–3, lane 3 valid cycles 4–6, values bit-exact, done in cycle 6 only.
- Starved stream: len=4, beats arrive every other cycle → bubbles with out_valid=0 and zero data between beats, skew preserved, done 3 cycles after the 4th pop.
- Back-pressure: no start, push 9 beats with FIFO_DEPTH=8 → in_ready low after 8th, 9th held; start len=9 → all 9 beats emerge in order.
- Edge cases: start len=0 → done pulse next cycle, busy stays 0; start pulsed during STREAM → ignored, beat count unchanged.
- Reset mid-DRAIN: assert rst_n low 1 cycle after last pop → no done, out_valid=0, next tile len=2 runs cleanly.
